// File: rtl/noc_pkt_injector.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkt_injector
// Brief    : Packetizer turning a descriptor plus payload words into a
//            HEAD/BODY/TAIL flit stream for a NoC router input port.
// Revision : 1.0 - initial release
// ============================================================================
module noc_pkt_injector #(
    parameter  int X_W    = 2,
    parameter  int Y_W    = 2,
    parameter  int SZ_W   = 8,
    parameter  int DATA_W = 32,
    parameter  int VC_W   = 1,
    localparam int FLIT_W = 2 + X_W + Y_W + SZ_W + DATA_W
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              pkt_valid_i,
    output logic              pkt_ready_o,
    input  logic [X_W-1:0]    pkt_x_i,
    input  logic [Y_W-1:0]    pkt_y_i,
    input  logic [SZ_W-1:0]   pkt_len_i,
    input  logic [VC_W-1:0]   pkt_vc_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [FLIT_W-1:0] flit_data_o,
    output logic              valid_o,
    output logic [VC_W-1:0]   vc_id_o,
    input  logic              ready_i,
    output logic              busy_o
);

    localparam logic [1:0] C_TYPE_HEAD = 2'b00;
    localparam logic [1:0] C_TYPE_BODY = 2'b01;
    localparam logic [1:0] C_TYPE_TAIL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [SZ_W-1:0]     len_q, len_d;
    logic [VC_W-1:0]     vc_q, vc_d;
    logic [SZ_W-1:0]     remaining_q, remaining_d;
    logic [FLIT_W-1:0]   flit_q, flit_d;
    logic                valid_q, valid_d;
    logic [VC_W-1:0]     vc_out_q, vc_out_d;
    logic                pkt_ready_q, pkt_ready_d;

    logic                w_slot_free;
    logic                w_wr_ready;
    logic                w_word_fire;
    logic [1:0]          w_body_type;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        len_d       = len_q;
        vc_d        = vc_q;
        remaining_d = remaining_q;
        flit_d      = flit_q;
        valid_d     = valid_q;
        vc_out_d    = vc_out_q;

        w_slot_free = !valid_q || ready_i;
        w_wr_ready  = (state_q != S_IDLE) && w_slot_free;
        w_word_fire = wr_valid_i && w_wr_ready;
        w_body_type = (remaining_q == SZ_W'(1)) ? C_TYPE_TAIL : C_TYPE_BODY;

        // A pop with nothing new to load leaves the output slot empty.
        if (w_slot_free && !w_word_fire) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pkt_valid_i && pkt_ready_q) begin
                    x_d     = pkt_x_i;
                    y_d     = pkt_y_i;
                    len_d   = pkt_len_i;
                    vc_d    = pkt_vc_i;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (w_word_fire) begin
                    flit_d   = {C_TYPE_HEAD, x_q, y_q, len_q, wr_data_i};
                    valid_d  = 1'b1;
                    vc_out_d = vc_q;
                    if (len_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        remaining_d = len_q;
                        state_d     = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (w_word_fire) begin
                    flit_d      = {w_body_type, {(X_W + Y_W + SZ_W){1'b0}}, wr_data_i};
                    valid_d     = 1'b1;
                    vc_out_d    = vc_q;
                    remaining_d = remaining_q - SZ_W'(1);
                    if (remaining_q == SZ_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so the port stays low while reset is held.
        pkt_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            len_q       <= '0;
            vc_q        <= '0;
            remaining_q <= '0;
            flit_q      <= '0;
            valid_q     <= 1'b0;
            vc_out_q    <= '0;
            pkt_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            len_q       <= len_d;
            vc_q        <= vc_d;
            remaining_q <= remaining_d;
            flit_q      <= flit_d;
            valid_q     <= valid_d;
            vc_out_q    <= vc_out_d;
            pkt_ready_q <= pkt_ready_d;
        end
    end

    assign pkt_ready_o = pkt_ready_q;
    assign wr_ready_o  = w_wr_ready;
    assign flit_data_o = flit_q;
    assign valid_o     = valid_q;
    assign vc_id_o     = vc_out_q;
    assign busy_o      = (state_q != S_IDLE) || valid_q;

endmodule
`default_nettype wire

// File: doc/noc_pkt_injector.md
# noc_pkt_injector

Packetizer that sits directly upstream of the NoC router input port. Accepts a packet descriptor (destination, length, VC) plus a stream of 32-bit payload words and emits a well-formed HEAD / BODY / TAIL flit sequence on the router's `flit_data_i` / `valid_i` / `vc_id_i` / `ready_o` interface. The flit output is registered, sustains one flit per cycle under backpressure, and keeps every packet contiguous on a single VC.

## Interface
- `X_W`, 2: width of the x destination field.
- `Y_W`, 2: width of the y destination field.
- `SZ_W`, 8: width of the pkt_size field; max additional flits is 2^SZ_W-1.
- `DATA_W`, 32: payload word width.
- `VC_W`, 1: VC id width.
- `FLIT_W`, 2+X_W+Y_W+SZ_W+DATA_W (46): flit width, derived, not overridable.

Ports:
- `clk` in 1: clock, rising edge.
- `arst` in 1: asynchronous reset, active-low.
- `pkt_valid_i` in 1: descriptor valid.
- `pkt_ready_o` out 1: descriptor accepted when both are high.
- `pkt_x_i` in X_W: destination x.
- `pkt_y_i` in Y_W: destination y.
- `pkt_len_i` in SZ_W: number of flits following the head; 0 means single-flit packet.
- `pkt_vc_i` in VC_W: VC for the whole packet.
- `wr_valid_i` in 1: payload word valid.
- `wr_ready_o` out 1: payload word accepted.
- `wr_data_i` in DATA_W: payload word.
- `flit_data_o` out FLIT_W: to router `flit_data_i`.
- `valid_o` out 1: to router `valid_i`.
- `vc_id_o` out VC_W: to router `vc_id_i`.
- `ready_i` in 1: from router `ready_o`.
- `busy_o` out 1: high whenever FSM is not IDLE or `valid_o` is high.

## Operation
- Flit layout, MSB to LSB: `{type_f[1:0], x_dest, y_dest, pkt_size, data}`.
- `type_f` encoding: HEAD=2'b00, BODY=2'b01, TAIL=2'b10. 2'b11 is never emitted.
- Head flit: x_dest, y_dest and pkt_size come from the latched descriptor; data is the first payload word.
- Body/tail flits: x_dest, y_dest and pkt_size are zero; data is the payload word.
- Output slot free: `slot_free = !valid_o || ready_i`.
- FSM states:
  - IDLE: `pkt_ready_o=1`, `wr_ready_o=0`. On descriptor handshake, latch x, y, len and vc into registers, then go to HEAD.
  - HEAD: `pkt_ready_o=0`, `wr_ready_o=slot_free`. On word handshake, load the head flit into the output register and set `valid_o=1`. If len==0, go to IDLE. Otherwise set `remaining=len` and go to BODY.
  - BODY: `wr_ready_o=slot_free`. On word handshake, type is TAIL if `remaining==1`, else BODY. Load the flit, decrement `remaining`, and go to IDLE when it reaches 0.
- Output register: updated only when `slot_free`; otherwise `flit_data_o`, `valid_o` and `vc_id_o` hold stable. If `valid_o && ready_i` and no new word is loaded, `valid_o` clears.
- `vc_id_o` equals the latched VC for every flit of a packet. The descriptor is never re-latched mid-packet.
- `remaining` is SZ_W bits. len=255 yields 256 flits; there is no wrap.

## Timing
- Reset (`arst` low, asynchronous) forces:
  - `valid_o=0`, `flit_data_o=0`, `vc_id_o=0`;
  - `pkt_ready_o=0` while `arst` is low, 1 in the first cycle after release;
  - `wr_ready_o=0`, `busy_o=0`;
  - FSM to IDLE, `remaining=0`.
- Reset mid-packet discards the partial packet; no tail is emitted.
- Latency: a word accepted at edge N appears on `valid_o` / `flit_data_o` immediately after edge N, i.e. one cycle.
- Throughput: one flit per cycle while `ready_i=1` and `wr_valid_i=1`.
- Packet boundary: one IDLE cycle between the tail load and the next descriptor accept. The next head can be loaded at the earliest 2 cycles after the tail load.
- Simultaneous events:
  - `ready_i` pop and new word load in the same cycle: the new flit replaces the old one with no bubble.
  - `ready_i` low with a word offered: `wr_ready_o=0` and the word waits.
- `pkt_valid_i` during HEAD/BODY is ignored; `pkt_ready_o=0`.

## Test plan
- Single-flit packet: descriptor x=2, y=3, len=0, vc=0, word 0xBEEFBEEF, `ready_i=1` → one flit with type=00, x=2, y=3, size=0, data=0xBEEFBEEF. `valid_o` is high for exactly 1 cycle, then `busy_o` falls.
- 3-flit packet: x=0, y=3, len=2, vc=1, words 0xDEADCAFE, 0x11111111, 0xFFFFFFFF → types HEAD, BODY, TAIL on consecutive cycles; the head carries size=2; `vc_id_o=1` on all three flits; body and tail flits have zero x/y/size fields.
- Backpressure: same 3-flit packet with `ready_i` low for 4 cycles after the head → head is held stable for 4 cycles, `wr_ready_o=0` throughout, and no flit is lost or duplicated.
- Back-to-back packets: two len=1 packets with descriptors always valid → 2-flit groups separated by exactly one idle cycle; the second head carries its own x/y.
- Reset mid-packet: `arst` driven low after the head of a len=4 packet → `valid_o` drops immediately; after release, a new len=0 packet emits a correct head and no stale BODY/TAIL flits appear.
- Max length: len=255 → 256 flits; exactly the last one has type TAIL; `busy_o` falls after the tail pops.
